if_instr_mem: RTL and testbench
===============================

# if_instr_mem

Instruction memory for the IF stage: consumes the byte address produced by the PC register and returns the addressed 32-bit instruction one cycle later for the IF/ID latch. Before execution, a byte-serial loader port fills it from the debug unit (UART path), assembling big-endian words and stopping on a HALT word or when memory is full. Memory contents survive reset; only the loader state and the output register reset.

## Interface
- SIZE_ADDR_PC, 32, width of the PC/byte address
- SIZE_INSTR, 32, instruction width
- MEM_DEPTH, 256, words of storage; must be a power of two
- HALT_INSTR, 32'hFFFF_FFFF, word that terminates loading and flags program end

- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_PC  in  SIZE_ADDR_PC  byte address from the PC register
- i_read_enable  in  1  pipeline enable; high = capture new instruction
- i_load_valid  in  1  loader byte valid
- i_load_byte  in  8  loader byte
- o_load_ready  out  1  loader may transfer this cycle
- i_load_clear  in  1  restart loading at word 0
- o_instr  out  SIZE_INSTR  fetched instruction (registered)
- o_halt_fetched  out  1  o_instr == HALT_INSTR
- o_load_done  out  1  loading finished (HALT written or memory full)
- o_word_count  out  clog2(MEM_DEPTH)+1  words written since reset/clear

## Operation
- Read: word index = i_PC[clog2(MEM_DEPTH)+1:2]; i_PC[1:0] ignored. If any i_PC bit above clog2(MEM_DEPTH)+1 is set, the read returns HALT_INSTR.
- i_read_enable low: o_instr holds (stall).
- Loader FSM, two states:
  - LOAD: o_load_ready = ~i_load_clear. A byte transfers when i_load_valid & o_load_ready. Byte 0 -> bits 31:24, byte 1 -> 23:16, byte 2 -> 15:8, byte 3 -> 7:0. On byte 3: write word at wr_ptr, wr_ptr++, byte_cnt -> 0. If the word equals HALT_INSTR or wr_ptr becomes MEM_DEPTH -> DONE.
  - DONE: o_load_ready = 0, o_load_done = 1; further bytes ignored.
  - i_load_clear (any state): wr_ptr = 0, byte_cnt = 0, partial word discarded, -> LOAD; clear beats a simultaneous valid byte (ready is low, so no transfer).
- o_word_count = wr_ptr; reaches MEM_DEPTH only at full.
- Memory array is not cleared by reset or by clear; stale words beyond wr_ptr remain readable.

## Timing
- Reset values: o_instr = 0 (NOP), o_halt_fetched = 0, o_load_done = 0, o_word_count = 0, FSM = LOAD, byte_cnt = 0, o_load_ready = 1 the cycle after reset.
- Read latency: 1 cycle; i_PC sampled at edge N appears on o_instr after edge N.
- Write: word committed at the edge accepting byte 3; visible to a read issued the following cycle.
- Same-cycle write and read of the same word: read returns old contents (read-before-write).
- o_load_done asserts the cycle after the final word write.
- Reset mid-word: partial word discarded, wr_ptr = 0; already written words remain.
- o_halt_fetched is combinational from o_instr, no extra latency.

## Structure
- Shared pipeline package: SIZE_INSTR, SIZE_ADDR_PC, HALT_INSTR, NOP encoding (0), loader state encoding (ST_LOAD, ST_DONE).
- One natural sub-module: if_word_assembler (byte_cnt, shift register, word-valid pulse); the top holds the array, wr_ptr, FSM and read register.

## Test plan
- Reset, then no load -> o_instr = 0, o_load_ready = 1, o_word_count = 0, o_load_done = 0.
- Load bytes 20,01,00,05 / 20,02,00,07 / FF,FF,FF,FF -> words 0x20010005, 0x20020007 written, o_word_count = 3, o_load_done = 1 one cycle later, o_load_ready = 0; read i_PC = 4 -> o_instr = 0x20020007 next cycle; i_PC = 8 -> o_halt_fetched = 1.
- Stall: i_PC 0 then 4 with i_read_enable low on the second -> o_instr stays 0x20010005; i_PC = 32'h0000_1000 with enable -> HALT_INSTR.
- Fill 256 non-HALT words -> o_word_count = 256, o_load_done = 1, extra bytes ignored.
- Send 2 bytes, assert i_load_clear with i_load_valid high -> byte dropped, next 4 bytes land at word 0, o_word_count = 1.
- Write word 5 while reading i_PC = 20 same cycle -> old value returned; re-read next cycle -> new value.

Source files
------------

// File: rtl/if_instr_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_instr_mem_pkg
//  Description : Shared pipeline definitions for the IF stage instruction
//                memory: instruction/address widths, HALT and NOP encodings
//                and the loader state encoding.
//  Ports       : (package, no ports)
//  Revision    : 1.0 - initial release
// ============================================================================
package if_instr_mem_pkg;

    localparam int                IF_SIZE_INSTR   = 32;
    localparam int                IF_SIZE_ADDR_PC = 32;
    localparam logic [31:0]       IF_HALT_INSTR   = 32'hFFFF_FFFF;
    localparam logic [31:0]       IF_NOP_INSTR    = 32'h0000_0000;

    // Loader progress: LOAD accepts bytes, DONE ignores them until a clear.
    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_DONE = 1'b1
    } load_state_t;

endpackage
`default_nettype wire

// File: rtl/if_instr_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_instr_mem_if
//  Description : Byte-serial loader link between the debug unit (master) and
//                the instruction memory (slave).
//  Signals     : i_load_valid  byte valid (master -> slave)
//                i_load_byte   byte payload (master -> slave)
//                i_load_clear  restart loading at word 0 (master -> slave)
//                o_load_ready  slave can take a byte this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_instr_mem_if;

    logic       i_load_valid;
    logic [7:0] i_load_byte;
    logic       i_load_clear;
    logic       o_load_ready;

    modport master (
        output i_load_valid,
        output i_load_byte,
        output i_load_clear,
        input  o_load_ready
    );

    modport slave (
        input  i_load_valid,
        input  i_load_byte,
        input  i_load_clear,
        output o_load_ready
    );

endinterface
`default_nettype wire

// File: rtl/if_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : if_word_assembler
//  Description : Collects four loader bytes into one big-endian 32-bit word.
//                The completed word is presented combinationally together
//                with a one-cycle valid pulse in the cycle byte 3 transfers.
//  Ports       : i_clk, i_reset   clock / synchronous active-high reset
//                clear_i          discard any partial word
//                byte_valid_i     a byte transfers this cycle
//                byte_i           transferred byte
//                word_o           assembled word (meaningful with valid)
//                word_valid_o     pulse: word_o is complete
//  Revision    : 1.0 - initial release
// ============================================================================
module if_word_assembler (
    input  wire logic        i_clk,
    input  wire logic        i_reset,
    input  wire logic        clear_i,
    input  wire logic        byte_valid_i,
    input  wire logic [7:0]  byte_i,
    output logic      [31:0] word_o,
    output logic             word_valid_o
);

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] shift_q,    shift_d;

    // The first three bytes sit in the shift register; the fourth is taken
    // straight from the input so the word can be written at its own edge.
    always_comb begin
        word_o       = {shift_q, byte_i};
        word_valid_o = byte_valid_i && (byte_cnt_q == 2'd3);
    end

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        if (clear_i) begin
            byte_cnt_d = 2'd0;
            shift_d    = 24'd0;
        end else if (byte_valid_i) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = {shift_q[15:0], byte_i};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'd0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_instr_mem.sv
`default_nettype none
// ============================================================================
//  Module      : if_instr_mem
//  Description : IF-stage instruction memory. Returns the word addressed by
//                i_PC one cycle later; filled beforehand by a byte-serial
//                loader that stops on a HALT word or when memory is full.
//                Array contents survive reset and clear.
//  Ports       : i_clk, i_reset    clock / synchronous active-high reset
//                i_PC              byte address from the PC register
//                i_read_enable     capture a new instruction (low = stall)
//                load_if           loader link (slave side)
//                o_instr           registered fetched instruction
//                o_halt_fetched    o_instr equals HALT_INSTR
//                o_load_done       loading finished
//                o_word_count      words written since reset/clear
//  Revision    : 1.0 - initial release
// ============================================================================
module if_instr_mem
    import if_instr_mem_pkg::*;
#(
    parameter int                    SIZE_ADDR_PC = IF_SIZE_ADDR_PC,
    parameter int                    SIZE_INSTR   = IF_SIZE_INSTR,
    parameter int                    MEM_DEPTH    = 256,
    parameter logic [SIZE_INSTR-1:0] HALT_INSTR   = IF_HALT_INSTR
) (
    input  wire logic                         i_clk,
    input  wire logic                         i_reset,
    input  wire logic [SIZE_ADDR_PC-1:0]      i_PC,
    input  wire logic                         i_read_enable,
    if_instr_mem_if.slave                     load_if,
    output logic      [SIZE_INSTR-1:0]        o_instr,
    output logic                              o_halt_fetched,
    output logic                              o_load_done,
    output logic      [$clog2(MEM_DEPTH):0]   o_word_count
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = AW + 1;

    logic [SIZE_INSTR-1:0] mem_q [MEM_DEPTH];
    logic [SIZE_INSTR-1:0] instr_q;
    load_state_t           state_q;
    logic [CW-1:0]         wr_ptr_q;

    logic                  w_xfer;
    logic [31:0]           w_word;
    logic                  w_word_valid;
    logic [SIZE_INSTR-1:0] w_word_ext;
    logic [CW-1:0]         w_ptr_inc;
    logic [AW-1:0]         w_rd_idx;
    logic                  w_oob;
    logic                  w_pc_unused;

    // ---------------- loader ----------------
    // Clear wins over a simultaneous valid byte by dropping ready.
    assign load_if.o_load_ready = (state_q == ST_LOAD) && !load_if.i_load_clear;
    assign w_xfer               = load_if.i_load_valid && load_if.o_load_ready;

    if_word_assembler u_asm (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .clear_i      (load_if.i_load_clear),
        .byte_valid_i (w_xfer),
        .byte_i       (load_if.i_load_byte),
        .word_o       (w_word),
        .word_valid_o (w_word_valid)
    );

    assign w_word_ext = SIZE_INSTR'(w_word);
    assign w_ptr_inc  = wr_ptr_q + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_reset || load_if.i_load_clear) begin
            state_q  <= ST_LOAD;
            wr_ptr_q <= '0;
        end else if (w_word_valid) begin
            wr_ptr_q <= w_ptr_inc;
            if ((w_word_ext == HALT_INSTR) || (w_ptr_inc == CW'(MEM_DEPTH))) begin
                state_q <= ST_DONE;
            end
        end
    end

    // Storage has no reset so a loaded program survives a pipeline reset.
    always_ff @(posedge i_clk) begin
        if (w_word_valid && !i_reset) begin
            mem_q[wr_ptr_q[AW-1:0]] <= w_word_ext;
        end
    end

    // ---------------- fetch ----------------
    assign w_rd_idx    = i_PC[AW+1:2];
    assign w_oob       = |(i_PC >> (AW + 2));
    assign w_pc_unused = ^i_PC[1:0];

    // Nonblocking read of mem_q gives read-before-write on a same-word clash.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            instr_q <= SIZE_INSTR'(IF_NOP_INSTR);
        end else if (i_read_enable) begin
            instr_q <= w_oob ? HALT_INSTR : mem_q[w_rd_idx];
        end
    end

    assign o_instr        = instr_q;
    assign o_halt_fetched = (instr_q == HALT_INSTR);
    assign o_load_done    = (state_q == ST_DONE);
    assign o_word_count   = wr_ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_if_instr_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_instr_mem
//  Description : Self-checking bench for if_instr_mem: directed program load,
//                stall/out-of-range reads, full fill, clear, read-before-write,
//                reset mid-word and a randomized mixed phase against a
//                byte-queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_instr_mem;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        re;
    logic [31:0] instr;
    logic        halt;
    logic        done;
    logic [8:0]  wc;

    always #5 clk = ~clk;

    if_instr_mem_if lif ();

    if_instr_mem dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_PC           (pc),
        .i_read_enable  (re),
        .load_if        (lif),
        .o_instr        (instr),
        .o_halt_fetched (halt),
        .o_load_done    (done),
        .o_word_count   (wc)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: word store with known-flags, pending byte queue.
    logic [31:0] mm [256];
    bit          mk [256];
    logic [7:0]  bq [$];
    int          mptr  = 0;
    bit          mdone = 1'b0;
    logic [31:0] einstr = 32'h0;
    bit          eknown = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check ready before the edge, step the model,
    // then check registered outputs after the edge.
    task automatic cyc(input logic [31:0] p, input logic r, input logic v,
                       input logic [7:0] b, input logic c, input logic rs);
        logic [31:0] w;
        pc = p; re = r; rst = rs;
        lif.i_load_valid = v; lif.i_load_byte = b; lif.i_load_clear = c;
        #1;
        if (!rs) chk("load_ready", {31'b0, lif.o_load_ready}, {31'b0, (!mdone && !c)});
        @(posedge clk);
        if (rs) begin
            einstr = 32'h0; eknown = 1'b1;
        end else if (r) begin
            if (p[31:10] != 22'd0) begin
                einstr = HALT; eknown = 1'b1;
            end else begin
                eknown = mk[p[9:2]];
                einstr = mm[p[9:2]];
            end
        end
        if (rs || c) begin
            mptr = 0; bq.delete(); mdone = 1'b0;
        end else if (v && !mdone) begin
            bq.push_back(b);
            if (bq.size() == 4) begin
                w = {bq[0], bq[1], bq[2], bq[3]};
                bq.delete();
                mm[mptr] = w; mk[mptr] = 1'b1;
                mptr++;
                if (w == HALT || mptr == 256) mdone = 1'b1;
            end
        end
        #1;
        if (eknown) begin
            chk("instr", instr, einstr);
            chk("halt_fetched", {31'b0, halt}, {31'b0, (einstr == HALT)});
        end
        chk("word_count", {23'b0, wc}, mptr);
        chk("load_done", {31'b0, done}, {31'b0, mdone});
    endtask

    task automatic idle(input logic [31:0] p, input logic r);
        cyc(p, r, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] p, input logic r);
        for (int k = 3; k >= 0; k--) cyc(p, r, 1'b1, w[8*k +: 8], 1'b0, 1'b0);
    endtask

    logic [31:0] rw;
    logic [31:0] old5;

    initial begin
        // Reset and idle
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        idle(0, 0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_ready", {31'b0, lif.o_load_ready}, 32'd1);
        chk("rst_count", {23'b0, wc}, 32'd0);
        chk("rst_done",  {31'b0, done}, 32'd0);

        // Directed program load
        send_word(32'h2001_0005, 0, 0);
        send_word(32'h2002_0007, 0, 0);
        send_word(HALT, 0, 0);
        chk("prog_count", {23'b0, wc}, 32'd3);
        chk("prog_done",  {31'b0, done}, 32'd1);
        idle(4, 1);
        chk("prog_rd4", instr, 32'h2002_0007);
        idle(8, 1);
        chk("prog_halt", {31'b0, halt}, 32'd1);

        // Stall and out-of-range read
        idle(0, 1);
        idle(4, 0);
        chk("stall_hold", instr, 32'h2001_0005);
        idle(32'h0000_1000, 1);
        chk("oob_read", instr, HALT);
        cyc(0, 0, 1, 8'hAB, 0, 0);
        chk("done_ignore", {23'b0, wc}, 32'd3);

        // Full fill with random non-HALT words, random gaps and reads
        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 256; i++) begin
            do rw = $urandom; while (rw == HALT);
            for (int k = 3; k >= 0; k--) begin
                if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 1100), 1'($urandom_range(0, 1)));
                cyc($urandom_range(0, 1100), 1'($urandom_range(0, 1)), 1'b1, rw[8*k +: 8], 1'b0, 1'b0);
            end
        end
        chk("full_count", {23'b0, wc}, 32'd256);
        chk("full_done",  {31'b0, done}, 32'd1);
        for (int k = 0; k < 4; k++) cyc(0, 0, 1, 8'h5A, 0, 0);
        chk("full_ignore", {23'b0, wc}, 32'd256);

        // Clear beats a valid byte; partial word dropped
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 8'h99, 0, 0);
        cyc(0, 0, 1, 8'h88, 0, 0);
        cyc(0, 0, 1, 8'h77, 1, 0);
        send_word(32'h1234_5678, 0, 0);
        chk("clr_count", {23'b0, wc}, 32'd1);
        idle(0, 1);
        chk("clr_word0", instr, 32'h1234_5678);

        // Same-cycle write and read of word 5
        for (int i = 1; i < 5; i++) send_word(32'h0100_0000 + i, 0, 0);
        old5 = mm[5];
        cyc(0, 0, 1, 8'hCA, 0, 0);
        cyc(0, 0, 1, 8'hFE, 0, 0);
        cyc(0, 0, 1, 8'hF0, 0, 0);
        cyc(20, 1, 1, 8'h0D, 0, 0);
        chk("rbw_old", instr, old5);
        idle(20, 1);
        chk("rbw_new", instr, 32'hCAFE_F00D);

        // Reset mid-word keeps written words
        cyc(0, 0, 1, 8'h11, 0, 0);
        cyc(0, 0, 1, 8'h22, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("rstmid_count", {23'b0, wc}, 32'd0);
        idle(0, 1);
        chk("rstmid_keep", instr, 32'h1234_5678);

        // Randomized mixed traffic
        for (int i = 0; i < 500; i++) begin
            cyc($urandom_range(0, 1100), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom),
                ($urandom_range(0, 40) == 0), ($urandom_range(0, 100) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
